// File: rtl/id_issue_queue.sv
// Dual-slot decoded-instruction issue queue between decode and register read.
// Takes up to two instructions per cycle and issues up to two in program order.
module id_issue_queue #(
    parameter int DEPTH = 8,
    parameter int PW    = 128
) (
    input  logic                     clk,
    input  logic                     aresetn,
    input  logic                     flush,
    input  logic [1:0]               in_valid,
    input  logic [PW-1:0]            in_payload0,
    input  logic [PW-1:0]            in_payload1,
    input  logic [4:0]               in_rd0,
    input  logic [4:0]               in_rd1,
    input  logic [4:0]               in_rj0,
    input  logic [4:0]               in_rj1,
    input  logic [4:0]               in_rk0,
    input  logic [4:0]               in_rk1,
    input  logic [1:0]               in_is_alu,
    input  logic [1:0]               in_serial,
    output logic                     in_ready,
    output logic [1:0]               out_valid,
    output logic [PW-1:0]            out_payload0,
    output logic [PW-1:0]            out_payload1,
    output logic [4:0]               out_rd0,
    output logic [4:0]               out_rd1,
    output logic [4:0]               out_rj0,
    output logic [4:0]               out_rj1,
    output logic [4:0]               out_rk0,
    output logic [4:0]               out_rk1,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0] head;
    logic [CW-1:0] tail;
    logic [CW-1:0] enq_cnt;
    logic [CW-1:0] deq_cnt;
    logic          enq;
    logic          pair_ok;

    logic [AW-1:0] t0_idx, t1_idx, h0_idx, h1_idx;

    logic [PW-1:0] mem_pl  [DEPTH];
    logic [4:0]    mem_rd  [DEPTH];
    logic [4:0]    mem_rj  [DEPTH];
    logic [4:0]    mem_rk  [DEPTH];
    logic          mem_alu [DEPTH];
    logic          mem_ser [DEPTH];

    assign count    = tail - head;
    assign in_ready = (count <= CW'(DEPTH - 2));
    assign enq      = in_valid[0] && in_ready && !flush;
    assign enq_cnt  = in_valid[1] ? CW'(2) : CW'(1);
    assign deq_cnt  = CW'(out_valid[0]) + CW'(out_valid[1]);

    assign t0_idx = tail[AW-1:0];
    assign t1_idx = t0_idx + AW'(1);
    assign h0_idx = head[AW-1:0];
    assign h1_idx = h0_idx + AW'(1);

    // Flush wins over both enqueue and dequeue in the same cycle.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (enq)
                tail <= tail + enq_cnt;
            if (out_ready)
                head <= head + deq_cnt;
        end
    end

    // Entry storage is never cleared; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_pl[t0_idx]  <= in_payload0;
            mem_rd[t0_idx]  <= in_rd0;
            mem_rj[t0_idx]  <= in_rj0;
            mem_rk[t0_idx]  <= in_rk0;
            mem_alu[t0_idx] <= in_is_alu[0];
            mem_ser[t0_idx] <= in_serial[0];
            if (in_valid[1]) begin
                mem_pl[t1_idx]  <= in_payload1;
                mem_rd[t1_idx]  <= in_rd1;
                mem_rj[t1_idx]  <= in_rj1;
                mem_rk[t1_idx]  <= in_rk1;
                mem_alu[t1_idx] <= in_is_alu[1];
                mem_ser[t1_idx] <= in_serial[1];
            end
        end
    end

    // head+1 may only ride along if it cannot observe or clobber head's result.
    always_comb begin
        pair_ok = mem_alu[h1_idx] && !mem_ser[h1_idx] && !mem_ser[h0_idx] &&
                  ((mem_rd[h0_idx] == 5'd0) ||
                   ((mem_rd[h0_idx] != mem_rj[h1_idx]) &&
                    (mem_rd[h0_idx] != mem_rk[h1_idx]) &&
                    (mem_rd[h0_idx] != mem_rd[h1_idx])));
    end

    always_comb begin
        out_valid[0] = (count != '0);
        out_valid[1] = (count >= CW'(2)) && pair_ok;

        out_payload0 = '0;
        out_rd0      = '0;
        out_rj0      = '0;
        out_rk0      = '0;
        out_payload1 = '0;
        out_rd1      = '0;
        out_rj1      = '0;
        out_rk1      = '0;

        if (out_valid[0]) begin
            out_payload0 = mem_pl[h0_idx];
            out_rd0      = mem_rd[h0_idx];
            out_rj0      = mem_rj[h0_idx];
            out_rk0      = mem_rk[h0_idx];
        end
        if (out_valid[1]) begin
            out_payload1 = mem_pl[h1_idx];
            out_rd1      = mem_rd[h1_idx];
            out_rj1      = mem_rj[h1_idx];
            out_rk1      = mem_rk[h1_idx];
        end
    end

endmodule

// File: tb/tb_id_issue_queue.sv
// Scoreboard bench for id_issue_queue: a program-order queue of expected
// instructions plus the pairing rule predicts every issue cycle.
module tb_id_issue_queue;

    localparam int DEPTH = 8;
    localparam int PW    = 128;

    typedef struct {
        logic [127:0] pl;
        logic [4:0]   rd;
        logic [4:0]   rj;
        logic [4:0]   rk;
        logic         alu;
        logic         ser;
    } ent_t;

    logic          clk = 1'b0;
    logic          aresetn;
    logic          flush;
    logic [1:0]    in_valid;
    logic [PW-1:0] in_payload0, in_payload1;
    logic [4:0]    in_rd0, in_rd1, in_rj0, in_rj1, in_rk0, in_rk1;
    logic [1:0]    in_is_alu, in_serial;
    logic          in_ready;
    logic [1:0]    out_valid;
    logic [PW-1:0] out_payload0, out_payload1;
    logic [4:0]    out_rd0, out_rd1, out_rj0, out_rj1, out_rk0, out_rk1;
    logic          out_ready;
    logic [3:0]    count;

    id_issue_queue #(.DEPTH(DEPTH), .PW(PW)) dut (
        .clk(clk), .aresetn(aresetn), .flush(flush), .in_valid(in_valid),
        .in_payload0(in_payload0), .in_payload1(in_payload1),
        .in_rd0(in_rd0), .in_rd1(in_rd1), .in_rj0(in_rj0), .in_rj1(in_rj1),
        .in_rk0(in_rk0), .in_rk1(in_rk1), .in_is_alu(in_is_alu), .in_serial(in_serial),
        .in_ready(in_ready), .out_valid(out_valid),
        .out_payload0(out_payload0), .out_payload1(out_payload1),
        .out_rd0(out_rd0), .out_rd1(out_rd1), .out_rj0(out_rj0), .out_rj1(out_rj1),
        .out_rk0(out_rk0), .out_rk1(out_rk1), .out_ready(out_ready), .count(count)
    );

    always #5 clk = ~clk;

    ent_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] seq = 0;
    logic        mon_en = 1'b0;
    ent_t        blank = '{default: 0};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ent_t mk(input logic [4:0] rd, input logic [4:0] rj, input logic [4:0] rk,
                                input logic alu, input logic ser);
        ent_t e;
        seq = seq + 1;
        e.pl  = {seq, $urandom(), $urandom(), $urandom()};
        e.rd  = rd;
        e.rj  = rj;
        e.rk  = rk;
        e.alu = alu;
        e.ser = ser;
        return e;
    endfunction

    function automatic ent_t mk_rand();
        return mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
    endfunction

    // Dual issue is legal only for an unserialised ALU op independent of head.
    function automatic logic can_pair(input ent_t a, input ent_t b);
        if (!b.alu || b.ser || a.ser) return 1'b0;
        if (a.rd == 0) return 1'b1;
        return (a.rd != b.rj) && (a.rd != b.rk) && (a.rd != b.rd);
    endfunction

    task automatic drive(input logic [1:0] v, input ent_t e0, input ent_t e1,
                         input logic ord, input logic fl);
        logic acc;
        in_valid    = v;
        in_payload0 = e0.pl;  in_payload1 = e1.pl;
        in_rd0 = e0.rd;  in_rj0 = e0.rj;  in_rk0 = e0.rk;
        in_rd1 = e1.rd;  in_rj1 = e1.rj;  in_rk1 = e1.rk;
        in_is_alu = {e1.alu, e0.alu};
        in_serial = {e1.ser, e0.ser};
        out_ready = ord;
        flush     = fl;
        acc = v[0] && (q.size() <= DEPTH - 2) && !fl;
        @(posedge clk);
        if (fl) q.delete();
        else if (acc) begin
            q.push_back(e0);
            if (v[1]) q.push_back(e1);
        end
        #1;
    endtask

    task automatic idle(input logic ord);
        drive(2'b00, blank, blank, ord, 1'b0);
    endtask

    // Monitor: compare outputs against the expected queue, retire what issues.
    int   mn;
    logic ev0, ev1;
    ent_t pop_e;
    always @(negedge clk) begin
        if (mon_en && aresetn) begin
            mn  = q.size();
            ev0 = (mn >= 1);
            ev1 = (mn >= 2) ? can_pair(q[0], q[1]) : 1'b0;
            check("count", 128'(count), 128'(mn));
            check("in_ready", 128'(in_ready), 128'(mn <= DEPTH - 2));
            check("out_valid", 128'(out_valid), 128'({ev1, ev0}));
            check("slot0_payload", out_payload0, ev0 ? q[0].pl : 128'd0);
            check("slot0_regs", 128'({out_rd0, out_rj0, out_rk0}),
                  ev0 ? 128'({q[0].rd, q[0].rj, q[0].rk}) : 128'd0);
            check("slot1_payload", out_payload1, ev1 ? q[1].pl : 128'd0);
            check("slot1_regs", 128'({out_rd1, out_rj1, out_rk1}),
                  ev1 ? 128'({q[1].rd, q[1].rj, q[1].rk}) : 128'd0);
            if (out_ready && !flush) begin
                if (ev0) pop_e = q.pop_front();
                if (ev1) pop_e = q.pop_front();
            end
        end
    end

    initial begin
        aresetn = 1'b0;
        drive_defaults();
        #12;
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_count", 128'(count), 128'd0);
        check("rst_payload0", out_payload0, 128'd0);
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        mon_en  = 1'b1;

        // Independent ALU pair issues together, then drains.
        drive(2'b11, mk(5, 1, 2, 1, 0), mk(8, 6, 7, 1, 0), 1'b1, 1'b0);
        check("t1_dual", 128'(out_valid), 128'b11);
        idle(1'b1);
        check("t1_drained", 128'(count), 128'd0);

        // RAW on rj splits the pair.
        drive(2'b11, mk(5, 1, 2, 1, 0), mk(9, 5, 7, 1, 0), 1'b1, 1'b0);
        check("t2_raw_single", 128'(out_valid), 128'b01);
        idle(1'b1);
        check("t2_second_alone", 128'(out_valid), 128'b01);
        check("t2_second_count", 128'(count), 128'd1);
        idle(1'b1);

        // r0 destination is never a hazard.
        drive(2'b11, mk(0, 1, 2, 1, 0), mk(4, 0, 0, 1, 0), 1'b1, 1'b0);
        check("t3_r0_dual", 128'(out_valid), 128'b11);
        idle(1'b1);

        // Fill under back-pressure; a fifth pair is ignored.
        for (int i = 0; i < 4; i++)
            drive(2'b11, mk(0, 1, 2, 1, 0), mk(3, 1, 2, 1, 0), 1'b0, 1'b0);
        check("t4_full_count", 128'(count), 128'd8);
        check("t4_full_ready", 128'(in_ready), 128'd0);
        drive(2'b11, mk(0, 1, 2, 1, 0), mk(3, 1, 2, 1, 0), 1'b0, 1'b0);
        check("t4_ignored", 128'(count), 128'd8);
        idle(1'b1);
        check("t4_release_count", 128'(count), 128'd6);
        check("t4_release_ready", 128'(in_ready), 128'd1);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Serial at head, then serial at head+1: never paired.
        drive(2'b11, mk(0, 0, 0, 0, 1), mk(2, 0, 0, 1, 0), 1'b1, 1'b0);
        check("t5_serial_head", 128'(out_valid), 128'b01);
        idle(1'b1);
        drive(2'b11, mk(0, 0, 0, 1, 0), mk(0, 0, 0, 1, 1), 1'b1, 1'b0);
        check("t5_serial_next", 128'(out_valid), 128'b01);
        idle(1'b1);
        idle(1'b1);

        // Flush with a same-cycle enqueue.
        for (int i = 0; i < 3; i++)
            drive(2'b11, mk_rand(), mk_rand(), 1'b0, 1'b0);
        check("t6_filled", 128'(count), 128'd6);
        drive(2'b11, mk_rand(), mk_rand(), 1'b1, 1'b1);
        check("t6_flush_count", 128'(count), 128'd0);
        check("t6_flush_valid", 128'(out_valid), 128'd0);
        check("t6_flush_ready", 128'(in_ready), 128'd1);

        // Twenty pairs back to back exercise wrap-around ordering.
        for (int i = 0; i < 20; i++)
            drive(2'b11, mk_rand(), mk_rand(), 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) idle(1'b1);
        check("t7_drained", 128'(count), 128'd0);

        // Random traffic with occasional flush and one mid-stream reset.
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [1:0] v;
            if (i == 150) begin
                aresetn  = 1'b0;
                in_valid = 2'b00;
                flush    = 1'b0;
                q.delete();
                #2;
                check("mid_rst_count", 128'(count), 128'd0);
                check("mid_rst_valid", 128'(out_valid), 128'd0);
                @(posedge clk);
                #1;
                aresetn = 1'b1;
            end
            r = $urandom_range(0, 3);
            v = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
            drive(v, mk_rand(), mk_rand(), $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
        end
        for (int i = 0; i < 10; i++) idle(1'b1);
        check("final_count", 128'(count), 128'd0);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    task automatic drive_defaults();
        flush       = 1'b0;
        in_valid    = 2'b00;
        in_payload0 = '0;  in_payload1 = '0;
        in_rd0 = '0;  in_rd1 = '0;  in_rj0 = '0;
        in_rj1 = '0;  in_rk0 = '0;  in_rk1 = '0;
        in_is_alu = '0;
        in_serial = '0;
        out_ready = 1'b0;
    endtask

endmodule
